// File: rtl/cnl_quad_pkg.sv
// Shared constants, FSM state encodings, job descriptor layout and the
// Q8.8 saturation helper for the convolution core of the accelerator quad.
package cnl_quad_pkg;

   localparam int NUM_CE      = 8;
   localparam int DATA_W      = 16;
   localparam int MAX_KERNELS = 16;
   localparam int MAX_KSIZE   = 3;

   localparam int BEAT_W = NUM_CE * DATA_W;
   localparam int PROD_W = 2 * DATA_W;
   localparam int DOT_W  = 36;
   localparam int ACC_W  = 40;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOAD_W   = 3'd1;
   localparam state_t ST_LOAD_WIN = 3'd2;
   localparam state_t ST_COMPUTE  = 3'd3;
   localparam state_t ST_OUTPUT   = 3'd4;
   localparam state_t ST_DONE     = 3'd5;

   localparam int JP_NK_LSB = 0;
   localparam int JP_NK_W   = 8;
   localparam int JP_KS_LSB = 8;
   localparam int JP_KS_W   = 4;
   localparam int JP_NW_LSB = 12;
   localparam int JP_NW_W   = 16;

   // Drop the 8 fractional bits of the Q16.16 sum, then clamp to Q8.8 range.
   function automatic logic signed [DATA_W-1:0] sat_q88(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> 8;
      if (sh > 40'sd32767)
         return 16'sh7fff;
      else if (sh < -40'sd32768)
         return 16'sh8000;
      else
         return sh[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/cnl_dot8.sv
// Combinational 8-lane signed Q8.8 multiply with a summing tree; one window
// tap against one weight tap per call.
module cnl_dot8
   import cnl_quad_pkg::*;
(
   input  logic [BEAT_W-1:0]       pix,
   input  logic [BEAT_W-1:0]       wgt,
   output logic signed [DOT_W-1:0] dot
);

   logic signed [PROD_W-1:0] prod [NUM_CE];

   for (genvar i = 0; i < NUM_CE; i++) begin : g_mul
      assign prod[i] = PROD_W'($signed(pix[DATA_W*i +: DATA_W]))
                     * PROD_W'($signed(wgt[DATA_W*i +: DATA_W]));
   end

   always_comb begin
      dot = '0;
      for (int i = 0; i < NUM_CE; i++)
         dot = dot + DOT_W'(prod[i]);
   end

endmodule

// File: rtl/cnn_conv_quad_core.sv
// Convolution core: loads a job's kernels, then for each window streams one
// saturated Q8.8 result per kernel. Optional ReLU on results: CNL_RELU_EN.
module cnn_conv_quad_core #(
   parameter int NUM_CE      = cnl_quad_pkg::NUM_CE,
   parameter int DATA_W      = cnl_quad_pkg::DATA_W,
   parameter int MAX_KERNELS = cnl_quad_pkg::MAX_KERNELS,
   parameter int MAX_KSIZE   = cnl_quad_pkg::MAX_KSIZE
)(
   input  logic                     clk_core,
   input  logic                     rst_n,
   input  logic                     job_start,
   output logic                     job_accept,
   input  logic [127:0]             job_parameters,
   output logic                     job_complete,
   input  logic                     job_complete_ack,
   input  logic                     weight_valid,
   output logic                     weight_ready,
   input  logic [NUM_CE*DATA_W-1:0] weight_data,
   input  logic                     pixel_valid,
   output logic                     pixel_ready,
   input  logic [NUM_CE*DATA_W-1:0] pixel_data,
   output logic                     result_valid,
   input  logic                     result_accept,
   output logic [DATA_W-1:0]        result_data
);

   import cnl_quad_pkg::*;

   localparam int WIN_D  = MAX_KSIZE * MAX_KSIZE;
   localparam int WBUF_D = MAX_KERNELS * WIN_D;
   localparam int WIDX_W = $clog2(WBUF_D + 1);
   localparam int TAP_W  = $clog2(WIN_D + 1);
   localparam int KIDX_W = $clog2(MAX_KERNELS + 1);

   state_t state;

   logic [KIDX_W-1:0]  nk_cfg, kern, nk_clean;
   logic [TAP_W-1:0]   kk, tap, p_cnt, kk_clean;
   logic [JP_NW_W-1:0] nw_cfg, win_cnt;
   logic [WIDX_W-1:0]  w_cnt, w_total, w_idx;

   logic [NUM_CE*DATA_W-1:0] w_buf   [WBUF_D];
   logic [NUM_CE*DATA_W-1:0] win_buf [WIN_D];

   logic signed [ACC_W-1:0]  acc;
   logic signed [DOT_W-1:0]  dot;
   logic signed [DATA_W-1:0] res_sat, res_out;

   logic [JP_NK_W-1:0] nk_raw;
   logic [JP_KS_W-1:0] ks_raw;
   logic [JP_NW_W-1:0] nw_raw;
   logic               unused_jp;

   logic w_fire, p_fire, p_last, res_done, more_kern, more_win, enter_compute;

   assign nk_raw    = job_parameters[JP_NK_LSB +: JP_NK_W];
   assign ks_raw    = job_parameters[JP_KS_LSB +: JP_KS_W];
   assign nw_raw    = job_parameters[JP_NW_LSB +: JP_NW_W];
   assign unused_jp = ^job_parameters[127:JP_NW_LSB+JP_NW_W];

   // Zero kernels means one; oversize counts clamp; any edge but 1 means 3.
   always_comb begin
      nk_clean = nk_raw[KIDX_W-1:0];
      if (nk_raw == '0)
         nk_clean = KIDX_W'(1);
      else if (nk_raw > JP_NK_W'(MAX_KERNELS))
         nk_clean = KIDX_W'(MAX_KERNELS);
      kk_clean = (ks_raw == JP_KS_W'(1)) ? TAP_W'(1) : TAP_W'(WIN_D);
   end

   assign w_fire        = (state == ST_LOAD_W)   && weight_valid && weight_ready;
   assign p_fire        = (state == ST_LOAD_WIN) && pixel_valid  && pixel_ready;
   assign p_last        = p_fire && (p_cnt == kk - TAP_W'(1));
   assign res_done      = (state == ST_OUTPUT) && result_valid && result_accept;
   assign more_kern     = (kern != nk_cfg - KIDX_W'(1));
   assign more_win      = (win_cnt != nw_cfg - JP_NW_W'(1));
   assign enter_compute = p_last || (res_done && more_kern);

   // Weights are stored kernel-major, so a kernel's taps are contiguous.
   assign w_idx = WIDX_W'(kern) * WIDX_W'(kk) + WIDX_W'(tap);

   cnl_dot8 u_dot8 (
      .pix (win_buf[tap]),
      .wgt (w_buf[w_idx]),
      .dot (dot)
   );

   assign res_sat = sat_q88(acc);
`ifdef CNL_RELU_EN
   assign res_out = res_sat[DATA_W-1] ? '0 : res_sat;
`else
   assign res_out = res_sat;
`endif

   // Datapath storage: not reset, validity is tracked by the control counters.
   always_ff @(posedge clk_core) begin
      if (w_fire)
         w_buf[w_cnt] <= weight_data;
      if (p_fire)
         win_buf[p_cnt] <= pixel_data;
      if (enter_compute)
         acc <= '0;
      else if (state == ST_COMPUTE)
         acc <= acc + ACC_W'(dot);
   end

   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         job_accept   <= 1'b0;
         job_complete <= 1'b0;
         weight_ready <= 1'b0;
         pixel_ready  <= 1'b0;
         result_valid <= 1'b0;
         result_data  <= '0;
         nk_cfg       <= '0;
         kk           <= '0;
         nw_cfg       <= '0;
         w_total      <= '0;
         w_cnt        <= '0;
         p_cnt        <= '0;
         tap          <= '0;
         kern         <= '0;
         win_cnt      <= '0;
      end else begin
         job_accept <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (job_start) begin
                  job_accept   <= 1'b1;
                  nk_cfg       <= nk_clean;
                  kk           <= kk_clean;
                  nw_cfg       <= nw_raw;
                  w_total      <= WIDX_W'(nk_clean) * WIDX_W'(kk_clean);
                  w_cnt        <= '0;
                  weight_ready <= 1'b1;
                  state        <= ST_LOAD_W;
               end
            end
            ST_LOAD_W: begin
               if (w_fire) begin
                  w_cnt <= w_cnt + WIDX_W'(1);
                  if (w_cnt == w_total - WIDX_W'(1)) begin
                     weight_ready <= 1'b0;
                     win_cnt      <= '0;
                     p_cnt        <= '0;
                     if (nw_cfg == '0) begin
                        job_complete <= 1'b1;
                        state        <= ST_DONE;
                     end else begin
                        pixel_ready <= 1'b1;
                        state       <= ST_LOAD_WIN;
                     end
                  end
               end
            end
            ST_LOAD_WIN: begin
               if (p_fire) begin
                  p_cnt <= p_cnt + TAP_W'(1);
                  if (p_last) begin
                     pixel_ready <= 1'b0;
                     tap         <= '0;
                     kern        <= '0;
                     state       <= ST_COMPUTE;
                  end
               end
            end
            ST_COMPUTE: begin
               if (tap == kk - TAP_W'(1))
                  state <= ST_OUTPUT;
               else
                  tap <= tap + TAP_W'(1);
            end
            ST_OUTPUT: begin
               if (!result_valid) begin
                  result_valid <= 1'b1;
                  result_data  <= res_out;
               end else if (result_accept) begin
                  result_valid <= 1'b0;
                  if (more_kern) begin
                     kern  <= kern + KIDX_W'(1);
                     tap   <= '0;
                     state <= ST_COMPUTE;
                  end else if (more_win) begin
                     win_cnt     <= win_cnt + JP_NW_W'(1);
                     p_cnt       <= '0;
                     pixel_ready <= 1'b1;
                     state       <= ST_LOAD_WIN;
                  end else begin
                     job_complete <= 1'b1;
                     state        <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (job_complete_ack) begin
                  job_complete <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_conv_quad_core.sv
// Directed bench for cnn_conv_quad_core: hand-computed Q8.8 results, handshake
// behaviour, backpressure, descriptor cleanup and mid-job reset.
module tb_cnn_conv_quad_core;

   localparam int NUM_CE = 8;

   logic         clk_core = 1'b0;
   logic         rst_n;
   logic         job_start;
   logic         job_accept;
   logic [127:0] job_parameters;
   logic         job_complete;
   logic         job_complete_ack;
   logic         weight_valid;
   logic         weight_ready;
   logic [127:0] weight_data;
   logic         pixel_valid;
   logic         pixel_ready;
   logic [127:0] pixel_data;
   logic         result_valid;
   logic         result_accept;
   logic [15:0]  result_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_core = ~clk_core;

   cnn_conv_quad_core dut (
      .clk_core         (clk_core),
      .rst_n            (rst_n),
      .job_start        (job_start),
      .job_accept       (job_accept),
      .job_parameters   (job_parameters),
      .job_complete     (job_complete),
      .job_complete_ack (job_complete_ack),
      .weight_valid     (weight_valid),
      .weight_ready     (weight_ready),
      .weight_data      (weight_data),
      .pixel_valid      (pixel_valid),
      .pixel_ready      (pixel_ready),
      .pixel_data       (pixel_data),
      .result_valid     (result_valid),
      .result_accept    (result_accept),
      .result_data      (result_data)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mk_jp(input int nk, input int ks, input int nw);
      logic [127:0] j;
      j        = '0;
      j[7:0]   = nk[7:0];
      j[11:8]  = ks[3:0];
      j[27:12] = nw[15:0];
      return j;
   endfunction

   task automatic start_job(input logic [127:0] jp);
      job_parameters = jp;
      job_start      = 1'b1;
      @(negedge clk_core);
      check_val("job_accept_pulse", 32'(job_accept), 1);
      job_start = 1'b0;
      @(negedge clk_core);
      check_val("job_accept_clear", 32'(job_accept), 0);
   endtask

   task automatic send_w(input int n, input logic [15:0] lane);
      logic tmo;
      tmo          = 1'b0;
      weight_data  = {NUM_CE{lane}};
      weight_valid = 1'b1;
      for (int i = 0; i < n && !tmo; i++) begin
         int t;
         t = 0;
         while (!weight_ready && t < 50) begin
            @(negedge clk_core);
            t++;
         end
         if (!weight_ready) tmo = 1'b1;
         else @(negedge clk_core);
      end
      weight_valid = 1'b0;
      check_val("weight_stream_timeout", 32'(tmo), 0);
   endtask

   task automatic send_p(input int n, input logic [15:0] lane);
      logic tmo;
      tmo         = 1'b0;
      pixel_data  = {NUM_CE{lane}};
      pixel_valid = 1'b1;
      for (int i = 0; i < n && !tmo; i++) begin
         int t;
         t = 0;
         while (!pixel_ready && t < 50) begin
            @(negedge clk_core);
            t++;
         end
         if (!pixel_ready) tmo = 1'b1;
         else @(negedge clk_core);
      end
      pixel_valid = 1'b0;
      check_val("pixel_stream_timeout", 32'(tmo), 0);
   endtask

   task automatic wait_result(output int lat);
      int t;
      t = 0;
      while (!result_valid && t < 200) begin
         @(negedge clk_core);
         t++;
      end
      lat = t;
      check_val("result_valid_timeout", 32'(result_valid), 1);
   endtask

   task automatic take_result(input string tag, input logic [15:0] exp);
      check_val(tag, 32'(result_data), 32'(exp));
      result_accept = 1'b1;
      @(negedge clk_core);
      result_accept = 1'b0;
      check_val("result_valid_drop", 32'(result_valid), 0);
   endtask

   task automatic finish_job();
      int t;
      t = 0;
      while (!job_complete && t < 50) begin
         @(negedge clk_core);
         t++;
      end
      check_val("job_complete_set", 32'(job_complete), 1);
      job_complete_ack = 1'b1;
      @(negedge clk_core);
      job_complete_ack = 1'b0;
      check_val("job_complete_clear", 32'(job_complete), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;
      logic seen;
      logic [15:0] held;
      logic [15:0] neg_exp;

`ifdef CNL_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'hB800;
`endif

      rst_n            = 1'b0;
      job_start        = 1'b0;
      job_parameters   = '0;
      job_complete_ack = 1'b0;
      weight_valid     = 1'b0;
      weight_data      = '0;
      pixel_valid      = 1'b0;
      pixel_data       = '0;
      result_accept    = 1'b0;
      repeat (2) @(negedge clk_core);
      check_val("reset_outputs",
                32'({job_accept, job_complete, weight_ready, pixel_ready, result_valid, result_data}), 0);
      rst_n = 1'b1;
      @(negedge clk_core);

      // K=1: 8 lanes of 1.0*2.0 = 16.0
      start_job(mk_jp(1, 1, 1));
      send_w(1, 16'h0200);
      send_p(1, 16'h0100);
      wait_result(lat);
      check_val("k1_latency", 32'(lat), 2);
      take_result("k1_result", 16'h1000);
      finish_job();

      // K=3, two kernels: +72.0 then -72.0
      start_job(mk_jp(2, 3, 1));
      send_w(9, 16'h0100);
      send_w(9, 16'hFF00);
      send_p(9, 16'h0100);
      wait_result(lat);
      check_val("k3_latency", 32'(lat), 10);
      take_result("k3_kernel0", 16'h4800);
      wait_result(lat);
      check_val("k3_next_kernel_latency", 32'(lat), 10);
      take_result("k3_kernel1", neg_exp);
      finish_job();

      // Saturation at the positive limit
      start_job(mk_jp(1, 3, 1));
      send_w(9, 16'h7F00);
      send_p(9, 16'h7F00);
      wait_result(lat);
      take_result("saturate_pos", 16'h7FFF);
      finish_job();

      // kernel_size=5 acts as 3, job_start ignored in LOAD_W, backpressure, 2 windows
      start_job(mk_jp(1, 5, 2));
      seen      = 1'b0;
      job_start = 1'b1;
      repeat (3) begin
         @(negedge clk_core);
         seen = seen | job_accept;
      end
      job_start = 1'b0;
      @(negedge clk_core);
      seen = seen | job_accept;
      check_val("no_accept_in_load_w", 32'(seen), 0);
      send_w(9, 16'h0100);
      send_p(9, 16'h0100);
      wait_result(lat);
      check_val("ks5_latency", 32'(lat), 10);
      held = result_data;
      bad  = 0;
      repeat (10) begin
         @(negedge clk_core);
         if (!result_valid || result_data !== held || pixel_ready) bad++;
      end
      check_val("backpressure_stable", 32'(bad), 0);
      take_result("ks5_window0", 16'h4800);
      send_p(9, 16'h0080);
      wait_result(lat);
      take_result("ks5_window1", 16'h2400);
      finish_job();

      // num_windows=0: done right after the weights
      start_job(mk_jp(2, 1, 0));
      send_w(2, 16'h0100);
      check_val("nw0_done", 32'(job_complete), 1);
      check_val("nw0_no_pixels", 32'({pixel_ready, result_valid}), 0);
      finish_job();

      // num_kernels=0 treated as one kernel
      start_job(mk_jp(0, 1, 1));
      send_w(1, 16'h0100);
      send_p(1, 16'h0100);
      wait_result(lat);
      take_result("nk0_result", 16'h0800);
      finish_job();

      // Reset during COMPUTE, then a fresh job
      start_job(mk_jp(1, 3, 1));
      send_w(9, 16'h0100);
      send_p(9, 16'h0100);
      repeat (3) @(negedge clk_core);
      rst_n = 1'b0;
      #1;
      check_val("midjob_reset_outputs",
                32'({job_accept, job_complete, weight_ready, pixel_ready, result_valid, result_data}), 0);
      @(negedge clk_core);
      rst_n = 1'b1;
      @(negedge clk_core);
      start_job(mk_jp(1, 1, 1));
      send_w(1, 16'h0300);
      send_p(1, 16'h0100);
      wait_result(lat);
      take_result("post_reset_result", 16'h1800);
      finish_job();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
